// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, controller states and small helpers.
// Used by the init/refresh block, the access engine and the command bus mux.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_MRS       = 4'b0000;

  // A10 selects "all banks" on PRECHARGE
  localparam int          A10_BIT   = 10;
  localparam logic [12:0] A_PRE_ALL = 13'(1 << A10_BIT);

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_PRE_ALL,
    ST_INIT_TRP,
    ST_INIT_AR,
    ST_INIT_TRFC,
    ST_MRS,
    ST_TMRD,
    ST_IDLE,
    ST_REF_PRE,
    ST_REF_TRP,
    ST_REF_AR,
    ST_REF_TRFC
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_wait_ctr.sv
// Loadable down-counter for command spacing and the power-up delay.
// done is high while the count sits at zero; the count holds at zero.
module sdram_wait_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: a load wins, otherwise step down towards zero and stop there.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - ONE;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up initialiser and auto-refresh scheduler.
// Owns the command bus during init and during each granted refresh; otherwise
// counts refresh intervals and requests the bus from the access engine.
module sdram_init_refresh
  import sdram_pkg::*;
#(
  parameter int          POWERUP_CYC    = 20000,
  parameter int          TRP_CYC        = 2,
  parameter int          TRFC_CYC       = 7,
  parameter int          TMRD_CYC       = 2,
  parameter int          INIT_REFRESHES = 8,
  parameter int          REFI_CYC       = 780,
  parameter logic [12:0] MODE_REG       = 13'h020
) (
  input  logic        clk,
  input  logic        rst,
  output logic        sd_ck_en,
  output logic        sd_cke,
  output logic [3:0]  sd_cmd,
  output logic [12:0] sd_a,
  output logic [1:0]  sd_ba,
  output logic        bus_own,
  output logic        init_done,
  output logic        ref_req,
  input  logic        ref_gnt,
  output logic        ref_overrun
);

  localparam int TMAX = max_int(max_int(POWERUP_CYC, REFI_CYC),
                                max_int(TRFC_CYC, max_int(TRP_CYC, TMRD_CYC)));
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (INIT_REFRESHES > 1) ? $clog2(INIT_REFRESHES) : 1;

  // Waits are loaded on the command edge with T-1 so the next command lands exactly T cycles later.
  localparam logic [TW-1:0] PWR_LOAD  = TW'(POWERUP_CYC - 1);
  localparam logic [TW-1:0] TRP_LOAD  = TW'(TRP_CYC - 1);
  localparam logic [TW-1:0] TRFC_LOAD = TW'(TRFC_CYC - 1);
  localparam logic [TW-1:0] TMRD_LOAD = TW'(TMRD_CYC - 1);
  localparam logic [TW-1:0] REFI_LAST = TW'(REFI_CYC - 1);
  localparam logic [TW-1:0] TW_ONE    = TW'(1);
  localparam logic [IW-1:0] AR_LAST   = IW'(INIT_REFRESHES - 1);
  localparam logic [IW-1:0] AR_ONE    = IW'(1);
  localparam logic [2:0]    OWED_MAX  = 3'd7;

  state_t        state_q, state_d;
  logic          sd_ck_en_q, sd_ck_en_d;
  logic          sd_cke_q, sd_cke_d;
  logic [3:0]    sd_cmd_q, sd_cmd_d;
  logic [12:0]   sd_a_q, sd_a_d;
  logic          bus_own_q, bus_own_d;
  logic          init_done_q, init_done_d;
  logic          ref_req_q, ref_req_d;
  logic          ref_overrun_q, ref_overrun_d;
  logic [2:0]    owed_q, owed_d;
  logic [TW-1:0] refi_q, refi_d;
  logic [IW-1:0] ar_cnt_q, ar_cnt_d;

  logic          wc_load;
  logic [TW-1:0] wc_val;
  logic          wc_done;
  logic          tick;
  logic          dec;

  sdram_wait_ctr #(.W(TW)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (wc_load),
    .load_val (wc_val),
    .done     (wc_done)
  );

  // Sequencer: next state, the command for the coming cycle and the wait to start with it.
  always_comb begin
    state_d     = state_q;
    sd_ck_en_d  = 1'b1;
    sd_cke_d    = sd_cke_q;
    sd_cmd_d    = CMD_NOP;
    sd_a_d      = '0;
    bus_own_d   = bus_own_q;
    init_done_d = init_done_q;
    ar_cnt_d    = ar_cnt_q;
    wc_load     = 1'b0;
    wc_val      = '0;
    unique case (state_q)
      ST_PWRUP: begin
        if (!sd_ck_en_q) begin
          wc_load = 1'b1;
          wc_val  = PWR_LOAD;
        end else if (wc_done) begin
          if (!sd_cke_q) begin
            sd_cke_d = 1'b1;
          end else begin
            state_d  = ST_PRE_ALL;
            sd_cmd_d = CMD_PRECHARGE;
            sd_a_d   = A_PRE_ALL;
            wc_load  = 1'b1;
            wc_val   = TRP_LOAD;
          end
        end
      end
      ST_PRE_ALL: state_d = ST_INIT_TRP;
      ST_INIT_TRP: begin
        if (wc_done) begin
          state_d  = ST_INIT_AR;
          sd_cmd_d = CMD_REFRESH;
          wc_load  = 1'b1;
          wc_val   = TRFC_LOAD;
        end
      end
      ST_INIT_AR: state_d = ST_INIT_TRFC;
      ST_INIT_TRFC: begin
        if (wc_done) begin
          wc_load = 1'b1;
          if (ar_cnt_q == AR_LAST) begin
            state_d  = ST_MRS;
            sd_cmd_d = CMD_MRS;
            sd_a_d   = MODE_REG;
            wc_val   = TMRD_LOAD;
          end else begin
            state_d  = ST_INIT_AR;
            sd_cmd_d = CMD_REFRESH;
            ar_cnt_d = ar_cnt_q + AR_ONE;
            wc_val   = TRFC_LOAD;
          end
        end
      end
      ST_MRS: state_d = ST_TMRD;
      ST_TMRD: begin
        if (wc_done) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          bus_own_d   = 1'b0;
        end
      end
      ST_IDLE: begin
        if (ref_req_q && ref_gnt) begin
          state_d   = ST_REF_PRE;
          bus_own_d = 1'b1;
          sd_cmd_d  = CMD_PRECHARGE;
          sd_a_d    = A_PRE_ALL;
          wc_load   = 1'b1;
          wc_val    = TRP_LOAD;
        end
      end
      ST_REF_PRE: state_d = ST_REF_TRP;
      ST_REF_TRP: begin
        if (wc_done) begin
          state_d  = ST_REF_AR;
          sd_cmd_d = CMD_REFRESH;
          wc_load  = 1'b1;
          wc_val   = TRFC_LOAD;
        end
      end
      ST_REF_AR: state_d = ST_REF_TRFC;
      ST_REF_TRFC: begin
        if (wc_done) begin
          state_d   = ST_IDLE;
          bus_own_d = 1'b0;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // Refresh interval timer and owed-refresh bookkeeping; a tick and a refresh on one edge cancel.
  always_comb begin
    tick          = init_done_q && (refi_q == REFI_LAST);
    dec           = (state_d == ST_REF_AR);
    refi_d        = (!init_done_q || tick) ? '0 : refi_q + TW_ONE;
    owed_d        = owed_q;
    ref_overrun_d = ref_overrun_q;
    if (tick && !dec) begin
      if (owed_q == OWED_MAX) ref_overrun_d = 1'b1;
      else                    owed_d        = owed_q + 3'd1;
    end else if (dec && !tick) begin
      owed_d = owed_q - 3'd1;
    end
    ref_req_d = (state_d == ST_IDLE) && (owed_d != 3'd0);
  end

  // State and registered outputs; reset aborts everything and restarts init.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_PWRUP;
      sd_ck_en_q    <= 1'b0;
      sd_cke_q      <= 1'b0;
      sd_cmd_q      <= CMD_INHIBIT;
      sd_a_q        <= '0;
      bus_own_q     <= 1'b1;
      init_done_q   <= 1'b0;
      ref_req_q     <= 1'b0;
      ref_overrun_q <= 1'b0;
      owed_q        <= '0;
      refi_q        <= '0;
      ar_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      sd_ck_en_q    <= sd_ck_en_d;
      sd_cke_q      <= sd_cke_d;
      sd_cmd_q      <= sd_cmd_d;
      sd_a_q        <= sd_a_d;
      bus_own_q     <= bus_own_d;
      init_done_q   <= init_done_d;
      ref_req_q     <= ref_req_d;
      ref_overrun_q <= ref_overrun_d;
      owed_q        <= owed_d;
      refi_q        <= refi_d;
      ar_cnt_q      <= ar_cnt_d;
    end
  end

  assign sd_ck_en    = sd_ck_en_q;
  assign sd_cke      = sd_cke_q;
  assign sd_cmd      = sd_cmd_q;
  assign sd_a        = sd_a_q;
  assign sd_ba       = 2'b00;
  assign bus_own     = bus_own_q;
  assign init_done   = init_done_q;
  assign ref_req     = ref_req_q;
  assign ref_overrun = ref_overrun_q;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Bench for sdram_init_refresh: directed stimulus pushes the expected bus events
// (commands, init_done rise, bus release, ref_req rise) with their cycle numbers;
// a monitor pops and compares each event as the DUT shows it.
module tb_sdram_init_refresh;
  import sdram_pkg::*;

  localparam int EV_CMD    = 0;
  localparam int EV_INIT   = 1;
  localparam int EV_BUSREL = 2;
  localparam int EV_REQ    = 3;

  typedef struct {
    int          kind;
    logic [3:0]  cmd;
    logic [12:0] addr;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ref_gnt;
  logic        sd_ck_en, sd_cke, bus_own, init_done, ref_req, ref_overrun;
  logic [3:0]  sd_cmd;
  logic [12:0] sd_a;
  logic [1:0]  sd_ba;

  exp_t exp_q[$];
  int   cyc;
  int   checks = 0;
  int   errors = 0;
  logic init_done_prev, bus_own_prev, ref_req_prev;

  sdram_init_refresh #(
    .POWERUP_CYC    (20),
    .REFI_CYC       (50),
    .INIT_REFRESHES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sd_ck_en    (sd_ck_en),
    .sd_cke      (sd_cke),
    .sd_cmd      (sd_cmd),
    .sd_a        (sd_a),
    .sd_ba       (sd_ba),
    .bus_own     (bus_own),
    .init_done   (init_done),
    .ref_req     (ref_req),
    .ref_gnt     (ref_gnt),
    .ref_overrun (ref_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number = rising edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic push_cmd(input logic [3:0] c, input logic [12:0] a, input int t);
    exp_t e;
    e.kind = EV_CMD; e.cmd = c; e.addr = a; e.cyc = t;
    exp_q.push_back(e);
  endtask

  task automatic push_ev(input int k, input int t);
    exp_t e;
    e.kind = k; e.cmd = CMD_NOP; e.addr = '0; e.cyc = t;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_cmd(CMD_PRECHARGE, 13'h0400, 22);
    push_cmd(CMD_REFRESH,   13'h0000, 24);
    push_cmd(CMD_REFRESH,   13'h0000, 31);
    push_cmd(CMD_MRS,       13'h0020, 38);
    push_ev(EV_INIT, 40);
    push_ev(EV_BUSREL, 40);
  endtask

  // One granted refresh: PRECHARGE ALL at p, REFRESH 2 later, bus back 9 after p.
  task automatic push_refresh(input int p, input bit with_busrel);
    push_cmd(CMD_PRECHARGE, 13'h0400, p);
    push_cmd(CMD_REFRESH,   13'h0000, p + 2);
    if (with_busrel) push_ev(EV_BUSREL, p + 9);
  endtask

  task automatic match_ev(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d cmd %0h @cyc %0d, nothing expected", kind, sd_cmd, cyc);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind(exp cyc %0d)", e.cyc), kind, e.kind);
      check($sformatf("event_cycle(kind %0d)", e.kind), cyc, e.cyc);
      if (e.kind == EV_CMD) begin
        check($sformatf("cmd(exp cyc %0d)", e.cyc), {27'd0, bus_own, sd_cmd}, {27'd0, 1'b1, e.cmd});
        check($sformatf("addr(exp cyc %0d)", e.cyc), {17'd0, sd_ba, sd_a}, {17'd0, 2'b00, e.addr});
      end
    end
  endtask

  // Monitor: detect bus events away from the clock edge and score them.
  always @(negedge clk) begin
    if (!rst) begin
      if (sd_cmd != CMD_NOP && sd_cmd != CMD_INHIBIT) match_ev(EV_CMD);
      if (init_done && !init_done_prev)               match_ev(EV_INIT);
      if (!bus_own && bus_own_prev)                   match_ev(EV_BUSREL);
      if (ref_req && !ref_req_prev)                   match_ev(EV_REQ);
    end
    init_done_prev = init_done;
    bus_own_prev   = bus_own;
    ref_req_prev   = ref_req;
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ck_en"},    {31'd0, sd_ck_en},    32'd0);
    check({tag, "_cke"},      {31'd0, sd_cke},      32'd0);
    check({tag, "_cmd"},      {28'd0, sd_cmd},      32'hF);
    check({tag, "_a"},        {19'd0, sd_a},        32'd0);
    check({tag, "_ba"},       {30'd0, sd_ba},       32'd0);
    check({tag, "_bus_own"},  {31'd0, bus_own},     32'd1);
    check({tag, "_init_done"},{31'd0, init_done},   32'd0);
    check({tag, "_ref_req"},  {31'd0, ref_req},     32'd0);
    check({tag, "_overrun"},  {31'd0, ref_overrun}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    ref_gnt = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst1");

    // Expected events for the whole first run, in time order.
    push_init();
    push_ev(EV_REQ, 90);
    push_refresh(91, 1'b1);
    push_ev(EV_REQ, 140);
    for (int k = 0; k < 8; k++) begin
      push_refresh(498 + 10 * k, 1'b1);
      if (k < 7) push_ev(EV_REQ, 507 + 10 * k);
    end
    push_ev(EV_REQ, 590);
    push_refresh(591, 1'b0);

    rst = 1'b0;
    #1 check("ck_en_before_first_edge", {31'd0, sd_ck_en}, 32'd0);

    // Power-up: clock on, NOPs, CKE low for 20 cycles then high before PRECHARGE.
    wait_cyc(1);
    check("ck_en_first_edge", {31'd0, sd_ck_en}, 32'd1);
    check("cmd_nop_first_edge", {28'd0, sd_cmd}, {28'd0, CMD_NOP});
    check("cke_low_first_edge", {31'd0, sd_cke}, 32'd0);
    wait_cyc(20);
    check("cke_low_cyc20", {31'd0, sd_cke}, 32'd0);
    wait_cyc(21);
    check("cke_high_cyc21", {31'd0, sd_cke}, 32'd1);
    check("cmd_nop_cyc21", {28'd0, sd_cmd}, {28'd0, CMD_NOP});
    wait_cyc(40);
    check("init_done_cyc40", {31'd0, init_done}, 32'd1);

    // Grant held high with nothing owed: must be ignored.
    wait_cyc(120);
    check("bus_free_gnt_idle", {31'd0, bus_own}, 32'd0);
    ref_gnt = 1'b0;

    // Starve refresh until the owed counter saturates.
    wait_cyc(489);
    check("overrun_before_sat", {31'd0, ref_overrun}, 32'd0);
    wait_cyc(490);
    check("overrun_at_sat", {31'd0, ref_overrun}, 32'd1);

    // Grant timed so a REFRESH issue lands on the interval tick at cycle 540.
    wait_cyc(497);
    ref_gnt = 1'b1;
    wait_cyc(547);
    check("req_after_tick_refresh", {31'd0, ref_req}, 32'd1);
    wait_cyc(577);
    check("req_drained", {31'd0, ref_req}, 32'd0);
    check("overrun_sticky", {31'd0, ref_overrun}, 32'd1);

    // Reset in the middle of the REFRESH spacing after cycle 593.
    wait_cyc(596);
    #2 rst = 1'b1;
    #1 chk_reset("rst2");
    check("queue_drained_run1", exp_q.size(), 32'd0);

    @(negedge clk);
    push_init();
    rst = 1'b0;
    wait_cyc(21);
    check("rerun_cke_high", {31'd0, sd_cke}, 32'd1);
    wait_cyc(45);
    check("rerun_init_done", {31'd0, init_done}, 32'd1);
    check("queue_drained_run2", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
